// File: rtl/round_ctrl_pkg.sv
// Shared types and constants for the memory-game round sequencer.
// Holds the FSM encoding, LFSR constants and the level-to-length mapping.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_GAP = 3'd3,
    ST_INPUT    = 3'd4,
    ST_JUDGE    = 3'd5,
    ST_CHECK    = 3'd6,
    ST_OVER     = 3'd7
  } state_t;

  localparam int SYM_W   = 2;
  localparam int SEQ_MAX = 8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Symbols per round: 4, 6, 8 for levels 1..3
  function automatic logic [3:0] seq_len(input logic [1:0] level);
    return 4'd2 + {1'b0, level, 1'b0};
  endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// Bundle between the round sequencer and its neighbours (buttons, display, calculator).
// master = sequencer side, slave = environment side.
interface round_ctrl_if;
  import game_pkg::*;

  logic             start;
  logic             btn_valid;
  logic [SYM_W-1:0] btn_sym;
  logic [1:0]       life_in;
  logic             show_valid;
  logic [SYM_W-1:0] show_sym;
  logic             calc_clr;
  logic             calc_en;
  logic             calc_combo;
  logic             calc_life;
  logic [1:0]       calc_level;
  logic             game_over;
  state_t           state_o;

  modport master (
    input  start, btn_valid, btn_sym, life_in,
    output show_valid, show_sym, calc_clr, calc_en, calc_combo, calc_life,
           calc_level, game_over, state_o
  );

  modport slave (
    output start, btn_valid, btn_sym, life_in,
    input  show_valid, show_sym, calc_clr, calc_en, calc_combo, calc_life,
           calc_level, game_over, state_o
  );

endinterface

// File: rtl/round_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advances every cycle; reset reseeds it.
// Maximal-length taps from a non-zero seed, so the state never reaches zero.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LFSR_SEED;
    else        state <= {state[14:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer: shows an LFSR-derived symbol sequence, collects guesses and strobes the calculator.
// All outputs registered; one guess per JUDGE/CHECK pair, guesses outside INPUT are dropped.
module round_ctrl
  import game_pkg::*;
#(
  parameter int SHOW_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 25_000_000
) (
  input logic          clk,
  input logic          reset,
  round_ctrl_if.master bus
);

  localparam logic [31:0] SHOW_LD = 32'(SHOW_TICKS - 1);
  localparam logic [31:0] GAP_LD  = 32'(GAP_TICKS - 1);

  state_t                             state, state_nxt;
  logic [2:0]                         idx, idx_nxt;
  logic [1:0]                         level, level_nxt;
  logic [31:0]                        cnt, cnt_nxt;
  logic                               hit, hit_nxt;
  logic [SEQ_MAX-1:0][SYM_W-1:0]      seq, seq_nxt;
  logic [15:0]                        lfsr_q;
  logic                               last;

  logic             show_valid_d;
  logic [SYM_W-1:0] show_sym_d;
  logic             calc_clr_d;
  logic             calc_en_d;
  logic             judge_d;
  logic             game_over_d;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_q)
  );

  assign last           = (idx == 3'(seq_len(level) - 4'd1));
  assign bus.state_o    = state;
  assign bus.calc_level = level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      level          <= '0;
      cnt            <= '0;
      hit            <= 1'b0;
      seq            <= '0;
      bus.show_valid <= 1'b0;
      bus.show_sym   <= '0;
      bus.calc_clr   <= 1'b0;
      bus.calc_en    <= 1'b0;
      bus.calc_combo <= 1'b1;
      bus.calc_life  <= 1'b1;
      bus.game_over  <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      level          <= level_nxt;
      cnt            <= cnt_nxt;
      hit            <= hit_nxt;
      seq            <= seq_nxt;
      bus.show_valid <= show_valid_d;
      bus.show_sym   <= show_sym_d;
      bus.calc_clr   <= calc_clr_d;
      bus.calc_en    <= calc_en_d;
      bus.calc_combo <= judge_d;
      bus.calc_life  <= judge_d;
      bus.game_over  <= game_over_d;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    level_nxt = level;
    cnt_nxt   = cnt;
    hit_nxt   = hit;
    seq_nxt   = seq;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          level_nxt = 2'd1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        seq_nxt   = lfsr_q;
        idx_nxt   = '0;
        cnt_nxt   = SHOW_LD;
        state_nxt = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (cnt == '0) begin
          cnt_nxt   = GAP_LD;
          state_nxt = ST_SHOW_GAP;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      ST_SHOW_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 32'd1;
        end else if (last) begin
          idx_nxt   = '0;
          state_nxt = ST_INPUT;
        end else begin
          idx_nxt   = idx + 3'd1;
          cnt_nxt   = SHOW_LD;
          state_nxt = ST_SHOW_ON;
        end
      end
      ST_INPUT: begin
        if (bus.btn_valid) begin
          hit_nxt   = (bus.btn_sym == seq[idx]);
          state_nxt = ST_JUDGE;
        end
      end
      ST_JUDGE: state_nxt = ST_CHECK;
      ST_CHECK: begin
        // life_in already carries the calculator's response to the JUDGE strobe
        if (!hit) begin
          if (bus.life_in == 2'd0) begin
            state_nxt = ST_OVER;
          end else begin
            idx_nxt   = '0;
            cnt_nxt   = SHOW_LD;
            state_nxt = ST_SHOW_ON;
          end
        end else if (!last) begin
          idx_nxt   = idx + 3'd1;
          state_nxt = ST_INPUT;
        end else begin
          if (level != 2'd3) level_nxt = level + 2'd1;
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with state
  always_comb begin
    show_valid_d = (state_nxt == ST_SHOW_ON);
    show_sym_d   = show_valid_d ? seq_nxt[idx_nxt] : '0;
    calc_clr_d   = (state == ST_IDLE || state == ST_OVER) && bus.start;
    calc_en_d    = (state_nxt == ST_JUDGE);
    judge_d      = calc_en_d ? hit_nxt : 1'b1;
    game_over_d  = (state_nxt == ST_OVER);
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with a small LFSR and calculator model.
module tb_round_ctrl;
  import game_pkg::*;

  localparam int SHOW = 4;
  localparam int GAP  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  round_ctrl_if bus();

  round_ctrl #(.SHOW_TICKS(SHOW), .GAP_TICKS(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int pos   = 0;
  int bad_strobe = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  lives;
  int          combo, score;
  logic [1:0]  exp_seq [8];

  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Calculator stand-in: 3 lives, combo restarts whenever combo input is low
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lives <= 2'd3; combo <= 1; score <= 0;
    end else if (bus.calc_clr) begin
      lives <= 2'd3; combo <= 1; score <= 0;
    end else begin
      if (bus.calc_en && !bus.calc_life && lives != 2'd0) lives <= lives - 2'd1;
      if (bus.calc_en && bus.calc_combo) begin
        score <= score + combo;
        combo <= combo + 1;
      end else if (!bus.calc_combo) begin
        combo <= 1;
      end
    end
  end
  assign bus.life_in = lives;

  always @(negedge clk) begin
    if (bus.state_o == ST_LOAD)
      for (int i = 0; i < 8; i++) exp_seq[i] <= m_lfsr[2*i +: 2];
    if (reset && bus.state_o != ST_JUDGE &&
        (bus.calc_combo !== 1'b1 || bus.calc_life !== 1'b1 || bus.calc_en !== 1'b0))
      bad_strobe <= bad_strobe + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {bus.state_o, bus.show_valid, bus.show_sym, bus.calc_clr, bus.calc_en,
            bus.calc_combo, bus.calc_life, bus.calc_level, bus.game_over};
  endfunction

  function automatic logic [12:0] pk(input state_t s, input logic sv, input logic [1:0] sym,
                                     input logic clr, input logic en, input logic cmb,
                                     input logic lf, input logic [1:0] lvl, input logic go);
    return {s, sv, sym, clr, en, cmb, lf, lvl, go};
  endfunction

  task automatic wait_state(input state_t s, input string name);
    int n;
    n = 0;
    while (bus.state_o !== s && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.state_o, s);
  endtask

  task automatic watch_show(input int n);
    for (int i = 0; i < n; i++) begin
      int w, run, gap;
      logic [1:0] sym;
      w = 0; run = 0; gap = 0;
      while (!bus.show_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      sym = bus.show_sym;
      check($sformatf("show_sym[%0d]", i), sym, exp_seq[i]);
      while (bus.show_valid && run < 100) begin
        @(negedge clk);
        run++;
      end
      check($sformatf("show_len[%0d]", i), run, SHOW);
      while (!bus.show_valid && bus.state_o == ST_SHOW_GAP && gap < 100) begin
        @(negedge clk);
        gap++;
      end
      check($sformatf("gap_len[%0d]", i), gap, GAP);
    end
    check("input_after_show", bus.state_o, ST_INPUT);
    pos = 0;
  endtask

  task automatic do_start(input string tag);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_load"}, outs(), pk(ST_LOAD, 0, 2'd0, 1, 0, 1, 1, 2'd1, 0));
    @(negedge clk);
    check({tag, "_first_sym"}, outs(), pk(ST_SHOW_ON, 1, exp_seq[0], 0, 0, 1, 1, 2'd1, 0));
  endtask

  typedef struct {
    int         show_n;
    bit         ok;
    state_t     nxt;
    logic [1:0] lvl_in;
    logic [1:0] lvl_out;
    logic [1:0] lives;
  } vec_t;

  function automatic vec_t mk(input int sn, input bit ok, input state_t nx,
                              input logic [1:0] li, input logic [1:0] lo, input logic [1:0] lv);
    vec_t v;
    v.show_n = sn; v.ok = ok; v.nxt = nx; v.lvl_in = li; v.lvl_out = lo; v.lives = lv;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int k);
    logic [1:0] sym;
    logic       c;
    if (v.show_n > 0) watch_show(v.show_n);
    wait_state(ST_INPUT, $sformatf("wait_input[%0d]", k));
    sym = v.ok ? exp_seq[pos] : exp_seq[pos] + 2'd1;
    c   = v.ok;
    bus.btn_valid = 1'b1;
    bus.btn_sym   = sym;
    @(negedge clk);
    bus.btn_valid = 1'b0;
    check($sformatf("judge[%0d]", k), outs(), pk(ST_JUDGE, 0, 2'd0, 0, 1, c, c, v.lvl_in, 0));
    @(negedge clk);
    check($sformatf("check[%0d]", k), outs(), pk(ST_CHECK, 0, 2'd0, 0, 0, 1, 1, v.lvl_in, 0));
    check($sformatf("life_in[%0d]", k), bus.life_in, v.lives);
    @(negedge clk);
    check($sformatf("next_state[%0d]", k), bus.state_o, v.nxt);
    check($sformatf("level[%0d]", k), bus.calc_level, v.lvl_out);
    check($sformatf("game_over[%0d]", k), bus.game_over, (v.nxt == ST_OVER));
    if (v.ok && v.nxt == ST_INPUT) pos++;
    else pos = 0;
  endtask

  vec_t vt [22];

  initial begin
    vt[0] = mk(4, 1, ST_INPUT,   2'd1, 2'd1, 2'd3);
    vt[1] = mk(0, 0, ST_SHOW_ON, 2'd1, 2'd1, 2'd2);
    vt[2] = mk(4, 1, ST_INPUT,   2'd1, 2'd1, 2'd2);
    vt[3] = mk(0, 1, ST_INPUT,   2'd1, 2'd1, 2'd2);
    vt[4] = mk(0, 1, ST_INPUT,   2'd1, 2'd1, 2'd2);
    vt[5] = mk(0, 1, ST_LOAD,    2'd1, 2'd2, 2'd2);
    vt[6] = mk(6, 1, ST_INPUT,   2'd2, 2'd2, 2'd2);
    for (int i = 7; i <= 10; i++) vt[i] = mk(0, 1, ST_INPUT, 2'd2, 2'd2, 2'd2);
    vt[11] = mk(0, 1, ST_LOAD,   2'd2, 2'd3, 2'd2);
    vt[12] = mk(8, 1, ST_INPUT,  2'd3, 2'd3, 2'd2);
    for (int i = 13; i <= 18; i++) vt[i] = mk(0, 1, ST_INPUT, 2'd3, 2'd3, 2'd2);
    vt[19] = mk(0, 1, ST_LOAD,   2'd3, 2'd3, 2'd2);
    vt[20] = mk(0, 0, ST_SHOW_ON, 2'd3, 2'd3, 2'd1);
    vt[21] = mk(8, 0, ST_OVER,   2'd3, 2'd3, 2'd0);

    bus.start = 1'b0; bus.btn_valid = 1'b0; bus.btn_sym = 2'd0;
    #3 reset = 1'b0;
    #1 check("reset_state", outs(), pk(ST_IDLE, 0, 2'd0, 0, 0, 1, 1, 2'd0, 0));
    @(negedge clk);
    reset = 1'b1;
    bus.btn_valid = 1'b1;
    @(negedge clk);
    bus.btn_valid = 1'b0;
    @(negedge clk);
    check("idle_hold", outs(), pk(ST_IDLE, 0, 2'd0, 0, 0, 1, 1, 2'd0, 0));

    do_start("start1");
    for (int i = 0; i < 20; i++) begin
      run_vec(vt[i], i);
      if (i == 5) begin
        check("score_lvl1", score, 11);
        check("combo_lvl1", combo, 5);
      end
    end

    // Level 3 repeats: guesses and start during display must be ignored
    begin
      int w;
      w = 0;
      while (!bus.show_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      bus.btn_valid = 1'b1;
      bus.btn_sym   = exp_seq[0];
      @(negedge clk);
      bus.btn_valid = 1'b0;
      check("btn_in_show", outs(), pk(ST_SHOW_ON, 1, exp_seq[0], 0, 0, 1, 1, 2'd3, 0));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_mid_round", outs(), pk(ST_SHOW_ON, 1, exp_seq[0], 0, 0, 1, 1, 2'd3, 0));
      wait_state(ST_INPUT, "wait_input_l3");
      pos = 0;
    end
    run_vec(vt[20], 20);
    run_vec(vt[21], 21);

    bus.btn_valid = 1'b1;
    bus.btn_sym   = exp_seq[0];
    @(negedge clk);
    bus.btn_valid = 1'b0;
    check("over_btn_a", outs(), pk(ST_OVER, 0, 2'd0, 0, 0, 1, 1, 2'd3, 1));
    @(negedge clk);
    check("over_btn_b", outs(), pk(ST_OVER, 0, 2'd0, 0, 0, 1, 1, 2'd3, 1));

    do_start("restart");
    watch_show(4);
    bus.btn_valid = 1'b1;
    bus.btn_sym   = exp_seq[0];
    @(negedge clk);
    bus.btn_valid = 1'b0;
    check("judge_pre_reset", outs(), pk(ST_JUDGE, 0, 2'd0, 0, 1, 1, 1, 2'd1, 0));
    #2 reset = 1'b0;
    #1 check("reset_in_judge", outs(), pk(ST_IDLE, 0, 2'd0, 0, 0, 1, 1, 2'd0, 0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", outs(), pk(ST_IDLE, 0, 2'd0, 0, 0, 1, 1, 2'd0, 0));
    do_start("reseed");
    watch_show(4);

    check("strobes_outside_judge", bad_strobe, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
